// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock, LSB slice first.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NUM_DIG = WIDTH / DIGIT;
    localparam int unsigned IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q;
    logic             cout_q, ovf_q, done_q;
    logic [IDX_W-1:0] idx_q;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [DIGIT-1:0] a_sl, b_sl;
    logic [DIGIT:0]   slice_sum;
    logic             msb_cin;
    logic             last_dig;

    // Operand conditioning at start: subtraction is a + ~b + 1, cin ignored.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_eff = sub ? ~b : b;
        c_eff = sub ? 1'b1 : cin;
`else
        b_eff = b;
        c_eff = cin;
`endif
    end

    // Select the current operand slices and merge the result slice into its final position.
    always_comb begin
        a_sl  = '0;
        b_sl  = '0;
        sum_d = sum_q;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_sl = a_q[k*DIGIT +: DIGIT];
                b_sl = b_q[k*DIGIT +: DIGIT];
            end
        end
        slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
        for (int k = 0; k < NUM_DIG; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sum_d[k*DIGIT +: DIGIT] = slice_sum[DIGIT-1:0];
            end
        end
        // Carry into the top bit of this slice, recovered from its sum bit.
        msb_cin  = slice_sum[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1];
        last_dig = (idx_q == IDX_W'(NUM_DIG - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun:  if (last_dig) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: latch operands on accept, then one slice per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= c_eff;
                        idx_q   <= '0;
                    end
                end
                StRun: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_sum[DIGIT];
                    idx_q   <= idx_q + 1'b1;
                    if (last_dig) begin
                        cout_q <= slice_sum[DIGIT];
                        ovf_q  <= msb_cin ^ slice_sum[DIGIT];
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        busy = (state_q == StRun);
        done = done_q;
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: one DIGIT=1 and one DIGIT=4 instance, both WIDTH=8.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, cin1 = 1'b0, start4 = 1'b0, cin4 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
    logic       busy1, done1, cout1, ovf1, busy4, done4, cout4, ovf4;
    logic [7:0] sum1, sum4;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub1 = 1'b0, sub4 = 1'b0;
`endif

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         e0;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   errors = 0, checks = 0, cyc = 0;
    int   done_cnt1 = 0, done_cnt4 = 0, issued1 = 0, issued4 = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub4),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the whole word.
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv,
                                   input logic cv, input logic sv);
        logic [7:0] be;
        logic [8:0] full;
        exp_t       e;
        be     = sv ? ~bv : bv;
        full   = {1'b0, av} + {1'b0, be} + (sv ? 9'd1 : {8'd0, cv});
        e.sum  = full[7:0];
        e.cout = full[8];
        e.ovf  = (av[7] == be[7]) && (full[7] != av[7]);
        e.e0   = 0;
        return e;
    endfunction

    function automatic logic cur_busy(input int which);
        return (which == 4) ? busy4 : busy1;
    endfunction

    task automatic drive(input int which, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic cv);
        if (which == 4) begin
            start4 = st; a4 = av; b4 = bv; cin4 = cv;
        end else begin
            start1 = st; a1 = av; b1 = bv; cin1 = cv;
        end
    endtask

    // Issue one operation at a negedge; keep start high with junk operands while running.
    task automatic op(input int which, input logic [7:0] av, input logic [7:0] bv,
                      input logic cv, input logic sv, input int gap);
        exp_t e;
        int   n;
        n    = (which == 4) ? 2 : 8;
        e    = model(av, bv, cv, sv);
        e.e0 = cyc + 1;
`ifdef SERIAL_ADDER_SUB_EN
        if (which == 4) sub4 = sv; else sub1 = sv;
`endif
        drive(which, 1'b1, av, bv, cv);
        if (which == 4) begin
            q4.push_back(e); issued4++;
        end else begin
            q1.push_back(e); issued1++;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("busy%0d_run", which), cur_busy(which), 1);
            drive(which, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
`ifdef SERIAL_ADDER_SUB_EN
            if (which == 4) sub4 = 1'($urandom); else sub1 = 1'($urandom);
`endif
        end
        @(negedge clk);
        chk($sformatf("busy%0d_after", which), cur_busy(which), 0);
        drive(which, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (gap) @(negedge clk);
    endtask

    // Monitor for the DIGIT=1 instance.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            done_cnt1++;
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL done1_unexpected: got done pulse, required none");
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("sum1", sum1, e.sum);
                chk("cout1", cout1, e.cout);
                chk("ovf1", ovf1, e.ovf);
                chk("latency1", cyc - e.e0, 8);
                chk("busy1_done", busy1, 0);
            end
        end
    end

    // Monitor for the DIGIT=4 instance.
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            done_cnt4++;
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL done4_unexpected: got done pulse, required none");
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("sum4", sum4, e.sum);
                chk("cout4", cout4, e.cout);
                chk("ovf4", ovf4, e.ovf);
                chk("latency4", cyc - e.e0, 2);
                chk("busy4_done", busy4, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sum1", sum1, 0);
        chk("rst_cout1", cout1, 0);
        chk("rst_ovf1", ovf1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_sum4", sum4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 2);
        op(1, 8'h7F, 8'h00, 1'b1, 1'b0, 1);
        op(4, 8'h3C, 8'h45, 1'b0, 1'b0, 1);
        // Back-to-back: second start lands on the done cycle of the first.
        op(1, 8'h20, 8'h30, 1'b0, 1'b0, 0);
        op(1, 8'h02, 8'h03, 1'b0, 1'b0, 2);

        // Abort in the fourth RUN cycle; no result must appear.
        drive(1, 1'b1, 8'h55, 8'h66, 1'b0);
        repeat (4) begin
            @(negedge clk);
            drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_sum1", sum1, 0);
        chk("abort_cout1", cout1, 0);
        chk("abort_ovf1", ovf1, 0);
        chk("abort_busy1", busy1, 0);
        chk("abort_done1", done1, 0);
        rst_n = 1'b1;
        op(1, 8'h10, 8'h20, 1'b0, 1'b0, 2);

`ifdef SERIAL_ADDER_SUB_EN
        op(1, 8'h05, 8'h07, 1'b0, 1'b1, 1);
        op(1, 8'h80, 8'h01, 1'b1, 1'b1, 1);
`endif

        for (int i = 0; i < 30; i++) begin
            s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`endif
            op(1, 8'($urandom), 8'($urandom), 1'($urandom), s, $urandom_range(0, 2));
        end
        for (int i = 0; i < 30; i++) begin
            s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`endif
            op(4, 8'($urandom), 8'($urandom), 1'($urandom), s, $urandom_range(0, 2));
        end

        for (int i = 0; i < 20 && (q1.size() + q4.size()) > 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("queue_drained", q1.size() + q4.size(), 0);
        chk("done1_count", done_cnt1, issued1);
        chk("done4_count", done_cnt4, issued4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
